// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: channel modes, register map
// and CTRL/STATUS field positions.
package multi_timer_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE     = 3'd0,
    MODE_UP       = 3'd1,
    MODE_DOWN     = 3'd2,
    MODE_FREE_RUN = 3'd3,
    MODE_PERIODIC = 3'd4,
    MODE_UP_DOWN  = 3'd5
  } mode_t;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_RELOAD = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_MODE_LSB   = 0;
  localparam int unsigned CTRL_MODE_W     = 3;
  localparam int unsigned CTRL_IRQ_EN_BIT = 3;
  localparam int unsigned CTRL_PRESC_LSB  = 4;

  localparam int unsigned STATUS_DONE_BIT = 0;
  localparam int unsigned STATUS_DIR_BIT  = 1;

  // Encodings 6 and 7 have no defined behaviour and are rejected on write.
  function automatic logic mode_legal(input logic [2:0] m);
    return m <= 3'd5;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: count/reload/ctrl registers, prescaler, sticky done flag,
// up/down direction and a per-register read mux.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned PRESC_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_count,
  input  logic                     we_ctrl,
  input  logic                     we_reload,
  input  logic                     we_status,
  input  logic [COUNTER_WIDTH-1:0] wdata,
  input  logic [1:0]               reg_sel,
  output logic [COUNTER_WIDTH-1:0] rdata,
  output logic                     irq
);

  localparam logic [COUNTER_WIDTH-1:0] C_ONE = COUNTER_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0]   P_ONE = PRESC_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] count_nxt;
  logic [COUNTER_WIDTH-1:0] reload;
  mode_t                    mode;
  mode_t                    mode_nxt;
  logic                     irq_en;
  logic                     done;
  logic                     done_set;
  logic                     dir;
  logic                     dir_nxt;
  logic [PRESC_WIDTH-1:0]   presc;
  logic [PRESC_WIDTH-1:0]   pcnt;
  logic                     tick;
  logic                     hold;

  assign tick = (mode != MODE_IDLE) && (pcnt == presc);
  // A COUNT or CTRL write in a tick cycle swallows that tick entirely.
  assign hold = we_count | we_ctrl;

  always_comb begin
    count_nxt = count;
    mode_nxt  = mode;
    dir_nxt   = dir;
    done_set  = 1'b0;
    if (tick && !hold) begin
      case (mode)
        MODE_UP: begin
          if (count >= reload) begin
            done_set = 1'b1;
            mode_nxt = MODE_IDLE;
          end else begin
            count_nxt = count + C_ONE;
          end
        end
        MODE_DOWN: begin
          if (count == '0) begin
            done_set = 1'b1;
            mode_nxt = MODE_IDLE;
          end else begin
            count_nxt = count - C_ONE;
          end
        end
        MODE_FREE_RUN: begin
          done_set  = (count == '1);
          count_nxt = count + C_ONE;
        end
        MODE_PERIODIC: begin
          if (count == '0) begin
            done_set  = 1'b1;
            count_nxt = reload;
          end else begin
            count_nxt = count - C_ONE;
          end
        end
        MODE_UP_DOWN: begin
          if (dir) begin
            if (count >= reload) dir_nxt = 1'b0;
            else                 count_nxt = count + C_ONE;
          end else begin
            if (count == '0) begin
              dir_nxt  = 1'b1;
              done_set = 1'b1;
            end else begin
              count_nxt = count - C_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      mode   <= MODE_IDLE;
      irq_en <= 1'b0;
      presc  <= '0;
      done   <= 1'b0;
      dir    <= 1'b1;
      pcnt   <= '0;
    end else begin
      count <= we_count ? wdata : count_nxt;
      if (we_reload) reload <= wdata;
      if (we_ctrl) begin
        mode   <= mode_t'(wdata[CTRL_MODE_LSB +: CTRL_MODE_W]);
        irq_en <= wdata[CTRL_IRQ_EN_BIT];
        presc  <= wdata[CTRL_PRESC_LSB +: PRESC_WIDTH];
        dir    <= 1'b1;
      end else begin
        mode <= mode_nxt;
        dir  <= dir_nxt;
      end
      // Set beats a simultaneous write-one-to-clear.
      if (done_set)                                done <= 1'b1;
      else if (we_status && wdata[STATUS_DONE_BIT]) done <= 1'b0;
      if (hold || tick || mode == MODE_IDLE) pcnt <= '0;
      else                                   pcnt <= pcnt + P_ONE;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_COUNT:  rdata = count;
      REG_CTRL: begin
        rdata[CTRL_MODE_LSB +: CTRL_MODE_W]   = mode;
        rdata[CTRL_IRQ_EN_BIT]                = irq_en;
        rdata[CTRL_PRESC_LSB +: PRESC_WIDTH]  = presc;
      end
      REG_RELOAD: rdata = reload;
      REG_STATUS: begin
        rdata[STATUS_DONE_BIT] = done;
        rdata[STATUS_DIR_BIT]  = dir;
      end
      default: ;
    endcase
  end

  assign irq = done & irq_en;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer peripheral: register address decode, access error
// detection, read-data mux and interrupt aggregation around NUM_CH channels.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter  int unsigned COUNTER_WIDTH = 32,
  parameter  int unsigned NUM_CH        = 4,
  parameter  int unsigned PRESC_WIDTH   = 8,
  localparam int unsigned ADDR_W        = ($clog2(NUM_CH) + 2 < 3) ? 3 : $clog2(NUM_CH) + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [COUNTER_WIDTH-1:0] wdata,
  output logic [COUNTER_WIDTH-1:0] rdata,
  output logic                     err,
  output logic [NUM_CH-1:0]        irq,
  output logic                     irq_any
);

  localparam int unsigned    CH_W     = ADDR_W - 2;
  localparam logic [CH_W:0]  NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic [CH_W-1:0]          ch_idx;
  logic [1:0]               reg_idx;
  logic                     ch_ok;
  logic                     bad_ctrl;
  logic                     wr_ok;
  logic                     rd_ok;
  logic [COUNTER_WIDTH-1:0] ch_rdata [NUM_CH];

  assign ch_idx   = addr[ADDR_W-1:2];
  assign reg_idx  = addr[1:0];
  assign ch_ok    = {1'b0, ch_idx} < NUM_CH_L;
  assign bad_ctrl = (reg_idx == REG_CTRL) && !mode_legal(wdata[CTRL_MODE_LSB +: CTRL_MODE_W]);

  assign err   = en & ((we & re) | ((we | re) & ~ch_ok) | (we & bad_ctrl));
  assign wr_ok = en & we & ~err;
  assign rd_ok = en & re & ~err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = wr_ok && (ch_idx == CH_W'(g));

    timer_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .PRESC_WIDTH   (PRESC_WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .we_count  (sel && reg_idx == REG_COUNT),
      .we_ctrl   (sel && reg_idx == REG_CTRL),
      .we_reload (sel && reg_idx == REG_RELOAD),
      .we_status (sel && reg_idx == REG_STATUS),
      .wdata     (wdata),
      .reg_sel   (reg_idx),
      .rdata     (ch_rdata[g]),
      .irq       (irq[g])
    );
  end

  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_idx == CH_W'(i)) rdata = ch_rdata[i];
      end
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed register scenarios plus random
// register traffic compared cycle by cycle against a behavioural model.
module tb_multi_timer;

  localparam int unsigned CW  = 32;
  localparam int unsigned NCH = 3;   // leaves channel index 3 unpopulated
  localparam int unsigned PW  = 8;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, we, re;
  logic [AW-1:0] addr;
  logic [CW-1:0] wdata;
  logic [CW-1:0] rdata;
  logic          err;
  logic [NCH-1:0] irq;
  logic          irq_any;

  multi_timer #(
    .COUNTER_WIDTH (CW),
    .NUM_CH        (NCH),
    .PRESC_WIDTH   (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .err     (err),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [CW-1:0] m_count  [NCH];
  logic [CW-1:0] m_reload [NCH];
  int            m_mode   [NCH];
  int            m_presc  [NCH];
  int            m_pcnt   [NCH];
  bit            m_irqen  [NCH];
  bit            m_done   [NCH];
  bit            m_dir    [NCH];

  logic [CW-1:0]  s_rdata;
  bit             s_err;
  logic [NCH-1:0] s_irq;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_count[i] = '0; m_reload[i] = '0; m_mode[i] = 0; m_presc[i] = 0;
      m_pcnt[i] = 0; m_irqen[i] = 0; m_done[i] = 0; m_dir[i] = 1;
    end
  endfunction

  function automatic bit m_err(bit e, bit w, bit r, logic [AW-1:0] a, logic [CW-1:0] d);
    int c  = int'(a[AW-1:2]);
    int rg = int'(a[1:0]);
    if (!e) return 0;
    if (w && r) return 1;
    if ((w || r) && c >= NCH) return 1;
    if (w && rg == 1 && int'(d[2:0]) >= 6) return 1;
    return 0;
  endfunction

  function automatic logic [CW-1:0] m_read(int c, int rg);
    case (rg)
      0: return m_count[c];
      1: return CW'(m_mode[c] + (m_irqen[c] ? 8 : 0) + m_presc[c] * 16);
      2: return m_reload[c];
      default: return CW'((m_dir[c] ? 2 : 0) + (m_done[c] ? 1 : 0));
    endcase
  endfunction

  function automatic void m_step(bit e, bit w, bit r, logic [AW-1:0] a, logic [CW-1:0] d);
    bit er = m_err(e, w, r, a, d);
    bit wr = e && w && !er;
    int c  = int'(a[AW-1:2]);
    int rg = int'(a[1:0]);
    for (int ch = 0; ch < NCH; ch++) begin
      bit wc   = wr && c == ch && rg == 0;
      bit wctl = wr && c == ch && rg == 1;
      bit wrl  = wr && c == ch && rg == 2;
      bit wst  = wr && c == ch && rg == 3;
      int old_mode = m_mode[ch];
      bit tick = old_mode != 0 && m_pcnt[ch] == m_presc[ch];
      bit setd = 0;
      if (tick && !wc && !wctl) begin
        case (old_mode)
          1: if (m_count[ch] >= m_reload[ch]) begin setd = 1; m_mode[ch] = 0; end
             else m_count[ch] = m_count[ch] + 32'd1;
          2: if (m_count[ch] == 0) begin setd = 1; m_mode[ch] = 0; end
             else m_count[ch] = m_count[ch] - 32'd1;
          3: begin
               if (m_count[ch] == 32'hFFFF_FFFF) setd = 1;
               m_count[ch] = m_count[ch] + 32'd1;
             end
          4: if (m_count[ch] == 0) begin setd = 1; m_count[ch] = m_reload[ch]; end
             else m_count[ch] = m_count[ch] - 32'd1;
          5: if (m_dir[ch]) begin
               if (m_count[ch] >= m_reload[ch]) m_dir[ch] = 0;
               else m_count[ch] = m_count[ch] + 32'd1;
             end else begin
               if (m_count[ch] == 0) begin m_dir[ch] = 1; setd = 1; end
               else m_count[ch] = m_count[ch] - 32'd1;
             end
          default: ;
        endcase
      end
      if (wc || wctl || old_mode == 0 || tick) m_pcnt[ch] = 0;
      else                                     m_pcnt[ch] = m_pcnt[ch] + 1;
      if (wc)  m_count[ch]  = d;
      if (wrl) m_reload[ch] = d;
      if (wctl) begin
        m_mode[ch]  = int'(d[2:0]);
        m_irqen[ch] = d[3];
        m_presc[ch] = int'(d[11:4]);
        m_dir[ch]   = 1;
      end
      if (setd)                m_done[ch] = 1;
      else if (wst && d[0])    m_done[ch] = 0;
    end
  endfunction

  task automatic cycle(input bit e, input bit w, input bit r, input logic [AW-1:0] a,
                       input logic [CW-1:0] d, input bit rs);
    bit             exp_err;
    logic [CW-1:0]  exp_rd;
    logic [NCH-1:0] exp_irq;
    @(negedge clk);
    en = e; we = w; re = r; addr = a; wdata = d; rst = rs;
    #1;
    exp_err = m_err(e, w, r, a, d);
    exp_rd  = (e && r && !exp_err) ? m_read(int'(a[AW-1:2]), int'(a[1:0])) : '0;
    for (int i = 0; i < NCH; i++) exp_irq[i] = m_done[i] & m_irqen[i];
    check_eq("err", CW'(err), CW'(exp_err));
    check_eq("rdata", rdata, exp_rd);
    check_eq("irq", CW'(irq), CW'(exp_irq));
    check_eq("irq_any", CW'(irq_any), CW'(|exp_irq));
    s_rdata = rdata; s_err = err; s_irq = irq;
    @(posedge clk);
    if (rs) model_reset();
    else    m_step(e, w, r, a, d);
  endtask

  task automatic wr(input int c, input int rg, input logic [CW-1:0] d);
    cycle(1, 1, 0, AW'(c * 4 + rg), d, 0);
  endtask

  task automatic rd(input int c, input int rg);
    cycle(1, 0, 1, AW'(c * 4 + rg), '0, 0);
  endtask

  logic [CW-1:0] seq_per [9] = '{0, 0, 2, 2, 1, 1, 0, 0, 2};
  logic [CW-1:0] seq_ud  [7] = '{0, 1, 2, 2, 1, 0, 0};

  initial begin
    rst = 1'b1; en = 0; we = 0; re = 0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    model_reset();

    // Reset state: all registers zero except STATUS dir
    for (int c = 0; c < NCH; c++)
      for (int rg = 0; rg < 4; rg++) begin
        rd(c, rg);
        check_eq("reset_reg", s_rdata, (rg == 3) ? 32'd2 : 32'd0);
        check_eq("reset_irq", CW'(s_irq), '0);
      end

    // ch1 DOWN from 2
    wr(1, 2, 3); wr(1, 1, 32'h2); wr(1, 0, 2);
    rd(1, 0); check_eq("down_c0", s_rdata, 2);
    rd(1, 0); check_eq("down_c1", s_rdata, 1);
    rd(1, 0); check_eq("down_c2", s_rdata, 0);
    rd(1, 3); check_eq("down_done", s_rdata, 3);
    rd(1, 1); check_eq("down_mode_idle", s_rdata, 0);
    wr(1, 3, 1);
    rd(1, 3); check_eq("down_w1c", s_rdata, 2);

    // ch2 PERIODIC, presc=1, irq_en
    wr(2, 2, 2); wr(2, 0, 0); wr(2, 1, 32'd28);
    for (int i = 0; i < 9; i++) begin
      rd(2, 0);
      check_eq("periodic_seq", s_rdata, seq_per[i]);
      if (i == 1) check_eq("periodic_irq_pre", CW'(s_irq), 0);
      if (i == 2) check_eq("periodic_irq_post", CW'(s_irq), 32'd4);
    end
    wr(2, 1, 0); wr(2, 3, 1);

    // ch0 UP_DOWN with RELOAD=2
    wr(0, 2, 2); wr(0, 0, 0); wr(0, 1, 5);
    for (int i = 0; i < 7; i++) begin
      rd(0, 0);
      check_eq("updown_seq", s_rdata, seq_ud[i]);
    end
    rd(0, 3); check_eq("updown_status", s_rdata, 3);

    // ch0 FREE_RUN wrap
    wr(0, 1, 0); wr(0, 3, 1); wr(0, 1, 3); wr(0, 0, 32'hFFFF_FFFF);
    rd(0, 0); check_eq("free_allones", s_rdata, 32'hFFFF_FFFF);
    rd(0, 3); check_eq("free_wrap_done", s_rdata, 3);

    // Collisions: COUNT write on tick, W1C against done set
    wr(0, 1, 0); wr(0, 3, 1); wr(0, 1, 3); wr(0, 0, 100);
    rd(0, 0); check_eq("coll_count_held", s_rdata, 100);
    rd(0, 0); check_eq("coll_count_next", s_rdata, 101);
    wr(0, 0, 32'hFFFF_FFFF); wr(0, 3, 1);
    rd(0, 3); check_eq("coll_set_wins", s_rdata, 3);

    // Illegal accesses
    wr(1, 1, 32'h18); wr(1, 0, 7);
    wr(1, 1, 32'hFE); check_eq("ill_ctrl_err", CW'(s_err), 1);
    rd(1, 1); check_eq("ill_ctrl_kept", s_rdata, 32'h18);
    cycle(1, 1, 1, AW'(4), 99, 0);
    check_eq("ill_wr_rd_err", CW'(s_err), 1);
    check_eq("ill_wr_rd_rdata", s_rdata, 0);
    rd(1, 0); check_eq("ill_wr_rd_kept", s_rdata, 7);
    wr(3, 0, 5); check_eq("ill_ch_wr_err", CW'(s_err), 1);
    rd(3, 0); check_eq("ill_ch_rd_err", CW'(s_err), 1);
    check_eq("ill_ch_rd_zero", s_rdata, 0);

    // Reset mid-count
    wr(0, 1, 3); cycle(0, 0, 0, '0, '0, 0); cycle(0, 0, 0, '0, '0, 1);
    rd(0, 0); check_eq("rst_mid_count", s_rdata, 0);
    rd(0, 1); check_eq("rst_mid_ctrl", s_rdata, 0);
    rd(0, 3); check_eq("rst_mid_status", s_rdata, 2);

    // Random register traffic
    for (int n = 0; n < 4000; n++) begin
      int unsigned kind = $urandom_range(0, 9);
      bit e  = $urandom_range(0, 4) != 0;
      bit w  = (kind <= 3) || (kind == 8);
      bit r  = (kind >= 4 && kind <= 8);
      bit rs = ($urandom_range(0, 799) == 0);
      logic [AW-1:0] a = AW'($urandom_range(0, 15));
      logic [CW-1:0] d;
      case (a[1:0])
        2'd0: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - CW'($urandom_range(0, 3))
                                              : CW'($urandom_range(0, 6));
        2'd1: d = CW'($urandom_range(0, 7) + 8 * $urandom_range(0, 1) + 16 * $urandom_range(0, 3))
                  | (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_F000) : 32'd0);
        2'd2: d = CW'($urandom_range(0, 6));
        default: d = $urandom;
      endcase
      cycle(e, w, r, a, d, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
